// File: rtl/vga_pkg.sv
// Shared helpers for the framebuffer arbiter: port-ID width and port-ID type.
package vga_pkg;

   function automatic int port_id_w(input int nport);
      return (nport <= 2) ? 1 : $clog2(nport);
   endfunction

   // Wide enough for the largest supported port count (4).
   localparam int AVN_PORT_ID_W = 2;
   typedef logic [AVN_PORT_ID_W-1:0] avn_port_id_t;

endpackage

// File: rtl/vga_fifo.sv
// Small synchronous FIFO; a pop in the same cycle frees a slot for a push into a full FIFO.
module vga_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [CW-1:0]    cnt;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign dout    = mem[rptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= ptr_inc(wptr);
         if (do_pop)  rptr <= ptr_inc(rptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/vga_avn_arbiter.sv
// N-port Avalon arbiter for the shared framebuffer: urgent override, burst-locked
// round robin, and a pending-read ID FIFO that steers responses back to the issuer.
module vga_avn_arbiter
   import vga_pkg::*;
#(
   parameter int AVN_AW       = 18,
   parameter int AVN_DW       = 16,
   parameter int NPORT        = 3,
   parameter int MAX_BURST    = 8,
   parameter int PENDING_READ = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NPORT-1:0]          urgent,
   input  logic [NPORT-1:0]          port_avn_read,
   input  logic [NPORT-1:0]          port_avn_write,
   input  logic [NPORT*AVN_AW-1:0]   port_avn_address,
   input  logic [NPORT*AVN_DW-1:0]   port_avn_writedata,
   input  logic [NPORT*AVN_DW/8-1:0] port_avn_byteenable,
   output logic [NPORT*AVN_DW-1:0]   port_avn_readdata,
   output logic [NPORT-1:0]          port_avn_readdatavalid,
   output logic [NPORT-1:0]          port_avn_waitrequest,
   output logic                      out_avn_read,
   output logic                      out_avn_write,
   output logic [AVN_AW-1:0]         out_avn_address,
   output logic [AVN_DW-1:0]         out_avn_writedata,
   output logic [AVN_DW/8-1:0]       out_avn_byteenable,
   input  logic [AVN_DW-1:0]         out_avn_readdata,
   input  logic                      out_avn_readdatavalid,
   input  logic                      out_avn_waitrequest,
   output logic                      err_orphan_rdv,
   output logic                      busy
);

   localparam int PW  = port_id_w(NPORT);
   localparam int BW  = $clog2(MAX_BURST + 1);
   localparam int BEW = AVN_DW / 8;

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t      state, state_nxt;
   logic [PW-1:0]    owner, owner_nxt, rr_ptr, rr_nxt, grant, rd_id;
   logic [BW-1:0]    bcnt, bcnt_nxt;
   logic [NPORT-1:0] req, rot;
   logic             lock, gnt_vld, accept, rd_block, rd_push;
   logic             fifo_full, fifo_empty;

   function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] p);
      return (int'(p) >= NPORT - 1) ? '0 : p + 1'b1;
   endfunction

   assign req      = port_avn_read | port_avn_write;
   assign lock     = (state == LOCKED);
   // A response popping this cycle makes room for a read pushed this cycle.
   assign rd_block = fifo_full & ~out_avn_readdatavalid;
   assign accept   = (out_avn_read | out_avn_write) & ~out_avn_waitrequest;
   assign rd_push  = accept & out_avn_read;

   // Urgent beats the lock; otherwise the lock owner; otherwise round robin from rr_ptr.
   always_comb begin
      gnt_vld = 1'b0;
      grant   = '0;
      rot     = NPORT'({req, req} >> rr_ptr);
      for (int i = NPORT - 1; i >= 0; i--)
         if (urgent[i] && req[i]) begin
            gnt_vld = 1'b1;
            grant   = PW'(i);
         end
      if (!gnt_vld && lock && req[owner]) begin
         gnt_vld = 1'b1;
         grant   = owner;
      end
      if (!gnt_vld)
         for (int k = NPORT - 1; k >= 0; k--)
            if (rot[k]) begin
               gnt_vld = 1'b1;
               grant   = PW'((int'(rr_ptr) + k) % NPORT);
            end
   end

   always_comb begin
      out_avn_read       = 1'b0;
      out_avn_write      = 1'b0;
      out_avn_address    = '0;
      out_avn_writedata  = '0;
      out_avn_byteenable = '0;
      port_avn_waitrequest = req;
      for (int i = 0; i < NPORT; i++)
         if (gnt_vld && grant == PW'(i)) begin
            out_avn_read       = port_avn_read[i] & ~rd_block;
            out_avn_write      = port_avn_write[i];
            out_avn_address    = port_avn_address[i*AVN_AW +: AVN_AW];
            out_avn_writedata  = port_avn_writedata[i*AVN_DW +: AVN_DW];
            out_avn_byteenable = port_avn_byteenable[i*BEW +: BEW];
            port_avn_waitrequest[i] = out_avn_waitrequest | (port_avn_read[i] & rd_block);
         end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      rr_nxt    = rr_ptr;
      bcnt_nxt  = bcnt;
      case (state)
         UNLOCKED:
            if (accept) begin
               owner_nxt = grant;
               bcnt_nxt  = BW'(1);
               if (MAX_BURST > 1) state_nxt = LOCKED;
               else               rr_nxt    = inc_mod(grant);
            end
         LOCKED:
            // Owner went idle or someone else (urgent) got through: release and move on.
            if ((accept && grant != owner) || !req[owner]) begin
               state_nxt = UNLOCKED;
               rr_nxt    = inc_mod(owner);
            end else if (accept) begin
               bcnt_nxt = bcnt + 1'b1;
               if (int'(bcnt) + 1 == MAX_BURST) begin
                  state_nxt = UNLOCKED;
                  rr_nxt    = inc_mod(owner);
               end
            end
         default: state_nxt = UNLOCKED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= UNLOCKED;
         owner          <= '0;
         rr_ptr         <= '0;
         bcnt           <= '0;
         err_orphan_rdv <= 1'b0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_nxt;
         bcnt   <= bcnt_nxt;
         if (out_avn_readdatavalid && fifo_empty) err_orphan_rdv <= 1'b1;
      end
   end

   vga_fifo #(
      .WIDTH (PW),
      .DEPTH (PENDING_READ)
   ) u_rd_id (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_push),
      .din   (grant),
      .pop   (out_avn_readdatavalid),
      .dout  (rd_id),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      port_avn_readdatavalid = '0;
      for (int i = 0; i < NPORT; i++)
         port_avn_readdatavalid[i] = out_avn_readdatavalid & ~fifo_empty & (rd_id == PW'(i));
   end

   assign port_avn_readdata = {NPORT{out_avn_readdata}};
   assign busy              = lock | ~fifo_empty;

endmodule

// File: tb/tb_vga_avn_arbiter.sv
// Bench for vga_avn_arbiter: per-cycle reference model plus directed scenario checks.
module tb_vga_avn_arbiter;
   localparam int AW = 18, DW = 16, NP = 3, MB = 4, PR = 4, BEW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]     urgent = '0, rd = '0, wr = '0;
   logic [NP*AW-1:0]  addr  = '0;
   logic [NP*DW-1:0]  wdata = '0;
   logic [NP*BEW-1:0] be    = '0;
   logic [NP*DW-1:0]  p_rdata;
   logic [NP-1:0]     p_rdv, p_wait;
   logic              o_rd, o_wr;
   logic [AW-1:0]     o_addr;
   logic [DW-1:0]     o_wdata;
   logic [BEW-1:0]    o_be;
   logic [DW-1:0]     m_rdata = '0;
   logic              m_rdv = 1'b0, m_wait = 1'b0;
   logic              err, busy;

   vga_avn_arbiter #(.AVN_AW(AW), .AVN_DW(DW), .NPORT(NP), .MAX_BURST(MB), .PENDING_READ(PR)) dut (
      .clk(clk), .rst(rst), .urgent(urgent),
      .port_avn_read(rd), .port_avn_write(wr), .port_avn_address(addr),
      .port_avn_writedata(wdata), .port_avn_byteenable(be),
      .port_avn_readdata(p_rdata), .port_avn_readdatavalid(p_rdv), .port_avn_waitrequest(p_wait),
      .out_avn_read(o_rd), .out_avn_write(o_wr), .out_avn_address(o_addr),
      .out_avn_writedata(o_wdata), .out_avn_byteenable(o_be),
      .out_avn_readdata(m_rdata), .out_avn_readdatavalid(m_rdv), .out_avn_waitrequest(m_wait),
      .err_orphan_rdv(err), .busy(busy));

   int n_tot = 0, n_pass = 0;
   int cyc = 0, lat = 3, inj_req = 0, inj_done = 0;
   int acc_log[$];

   typedef struct { int due; logic [AW-1:0] a; } mrd_t;
   mrd_t mq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: memory side plus arbitration state, checked every cycle.
   int  m_lock = 0, m_owner = 0, m_rr = 0, m_cnt = 0;
   bit  m_err = 0;
   int  pend[$];

   initial begin : cmp
      int g;
      bit blk, e_rd, e_wr, acc;
      logic [NP-1:0] req, e_wait, e_rdv;
      logic [AW+DW+BEW-1:0] e_bus;
      forever begin
         @(negedge clk);
         cyc++;
         m_rdv = 1'b0; m_rdata = '0;
         if (inj_req != inj_done) begin
            inj_done++;
            m_rdv = 1'b1; m_rdata = 16'hDEAD;
         end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            m_rdv = 1'b1; m_rdata = mq[0].a[15:0] ^ 16'h5A5A;
            void'(mq.pop_front());
         end
         #2;
         req = rd | wr;
         if (rst) begin
            m_lock = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_err = 0;
            pend.delete();
         end else begin
            g = -1;
            for (int i = 0; i < NP; i++) if (g < 0 && urgent[i] && req[i]) g = i;
            if (g < 0 && m_lock != 0 && req[m_owner]) g = m_owner;
            for (int k = 0; k < NP; k++) if (g < 0 && req[(m_rr + k) % NP]) g = (m_rr + k) % NP;
            blk  = (pend.size() >= PR) && !m_rdv;
            e_rd = (g >= 0) && rd[g] && !blk;
            e_wr = (g >= 0) && wr[g];
            e_bus = (g >= 0) ? {addr[g*AW +: AW], wdata[g*DW +: DW], be[g*BEW +: BEW]} : '0;
            e_wait = req;
            if (g >= 0) e_wait[g] = m_wait | (rd[g] & blk);
            e_rdv = (m_rdv && pend.size() > 0) ? NP'(1 << pend[0]) : '0;
            chk("out_read", o_rd, e_rd);
            chk("out_write", o_wr, e_wr);
            chk("out_bus", {o_addr, o_wdata, o_be}, e_bus);
            chk("waitrequest", p_wait, e_wait);
            chk("readdatavalid", p_rdv, e_rdv);
            chk("readdata", p_rdata, {NP{m_rdata}});
            chk("err_orphan", err, m_err);
            chk("busy", busy, (m_lock != 0) || (pend.size() > 0));

            acc = (e_rd || e_wr) && !m_wait;
            if (acc) acc_log.push_back(g);
            if (m_rdv) begin
               if (pend.size() > 0) void'(pend.pop_front());
               else m_err = 1'b1;
            end
            if (acc && e_rd) begin
               pend.push_back(g);
               mq.push_back('{due: cyc + lat, a: addr[g*AW +: AW]});
            end
            if (m_lock == 0) begin
               if (acc) begin
                  m_owner = g; m_cnt = 1;
                  if (MB > 1) m_lock = 1; else m_rr = (g + 1) % NP;
               end
            end else if ((acc && g != m_owner) || !req[m_owner]) begin
               m_lock = 0; m_rr = (m_owner + 1) % NP;
            end else if (acc) begin
               m_cnt++;
               if (m_cnt == MB) begin m_lock = 0; m_rr = (m_owner + 1) % NP; end
            end
         end
      end
   end

   task automatic set_port(input int i, input bit r, input bit w, input bit u, input logic [AW-1:0] a);
      rd[i] = r; wr[i] = w; urgent[i] = u;
      addr[i*AW +: AW]   = a;
      wdata[i*DW +: DW]  = a[15:0] ^ 16'h0F0F;
      be[i*BEW +: BEW]   = a[1:0] ^ 2'b10;
   endtask

   task automatic idle();
      rd = '0; wr = '0; urgent = '0; addr = '0; wdata = '0; be = '0; m_wait = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; idle();
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   int base, nseen, got;
   int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [NP-1:0] seen_v[2];
   logic [DW-1:0] seen_d[2];

   initial begin
      // Reset and idle
      do_reset();
      #3;
      chk("idle_rw", {o_rd, o_wr}, 2'b00);
      chk("idle_addr", o_addr, 0);
      chk("idle_wait", p_wait, 0);
      chk("idle_rdv_busy_err", {p_rdv, busy, err}, 0);

      // Burst lock: ports 0 and 1 read continuously, memory stalls two cycles
      do_reset();
      base = acc_log.size();
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         set_port(0, 1, 0, 0, 18'h00100 + 18'(c));
         set_port(1, 1, 0, 0, 18'h10200 + 18'(c));
         m_wait = (c == 2 || c == 3);
         #3;
         if (c == 2) chk("burst_stall_wait", p_wait[1:0], 2'b11);
         if (c == 5) chk("burst_p1_held", p_wait[1:0], 2'b10);
      end
      @(negedge clk); idle();
      chk("burst_len", acc_log.size() - base, 9);
      for (int i = 0; i < 9; i++)
         if (base + i < acc_log.size()) chk("burst_seq", acc_log[base + i], exp_seq[i]);
      repeat (6) @(negedge clk);

      // Urgent preemption of a lock held by port 1
      do_reset();
      @(negedge clk); set_port(1, 0, 1, 0, 18'h11000); #3;
      @(negedge clk); set_port(1, 0, 1, 0, 18'h11001); #3;
      @(negedge clk); set_port(1, 0, 1, 0, 18'h11002); set_port(2, 0, 1, 1, 18'h22000); #3;
      chk("urgent_write", {o_wr, o_addr}, {1'b1, 18'h22000});
      chk("urgent_wait", p_wait, 3'b010);
      @(negedge clk); set_port(2, 0, 0, 0, '0); set_port(0, 0, 1, 0, 18'h00300); set_port(1, 0, 1, 0, 18'h11003); #3;
      chk("post_urgent_grant", o_addr, 18'h00300);
      chk("post_urgent_wait", p_wait, 3'b010);
      @(negedge clk); idle();
      repeat (2) @(negedge clk);

      // Read routing: port 0 then port 2, latency 3
      do_reset(); lat = 3;
      @(negedge clk); set_port(0, 1, 0, 0, 18'h00123); #3;
      @(negedge clk); set_port(0, 0, 0, 0, '0); set_port(2, 1, 0, 0, 18'h20456); #3;
      @(negedge clk); idle();
      nseen = 0; seen_v[0] = '0; seen_v[1] = '0; seen_d[0] = '0; seen_d[1] = '0;
      for (int c = 0; c < 10; c++) begin
         #3;
         if (p_rdv != 0 && nseen < 2) begin
            seen_v[nseen] = p_rdv;
            seen_d[nseen] = (nseen == 0) ? p_rdata[0 +: DW] : p_rdata[2*DW +: DW];
            nseen++;
         end
         @(negedge clk);
      end
      chk("route_first", {seen_v[0], seen_d[0]}, {3'b001, 16'h5B79});
      chk("route_second", {seen_v[1], seen_d[1]}, {3'b100, 16'h5E0C});

      // FIFO full: 4 reads outstanding, locked writer passes, 5th read waits for a response
      do_reset(); lat = 12;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); set_port(0, 1, 0, 0, 18'h00400 + 18'(c)); #3;
      end
      @(negedge clk); idle(); set_port(1, 0, 1, 0, 18'h15000); set_port(2, 1, 0, 0, 18'h25000); #3;
      chk("full_write_pass", {o_wr, o_rd}, 2'b10);
      chk("full_wait_lock", p_wait, 3'b100);
      @(negedge clk); set_port(1, 0, 1, 0, 18'h15001); #3;
      @(negedge clk); set_port(1, 0, 0, 0, '0); #3;
      chk("full_read_blocked", {o_rd, p_wait}, {1'b0, 3'b100});
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk); #3;
         if (p_rdv != 0) begin
            got = 1;
            chk("full_fifth_accept", {o_rd, p_wait, p_rdv}, {1'b1, 3'b000, 3'b001});
         end
      end
      chk("full_rdv_seen", got, 1);
      @(negedge clk); idle();
      repeat (16) @(negedge clk);

      // Orphan response
      do_reset();
      #3; inj_req++;
      @(negedge clk); #3;
      chk("orphan_no_strobe", {m_rdv, p_rdv}, {1'b1, 3'b000});
      @(negedge clk); #3;
      chk("orphan_err_set", {err, busy}, 2'b10);
      repeat (3) @(negedge clk);
      #3; chk("orphan_err_sticky", err, 1);
      do_reset();
      #3; chk("orphan_err_cleared", err, 0);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tot);
      $fatal(1);
   end

endmodule
